// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_pkg
//  Purpose  : Shared constants and types for the interrupt injector slice.
//             INT_NONE is the "no interrupt" word seen by the processor;
//             state_t enumerates the presentation FSM.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package io_pkg;

  // All-zero instruction word means "no interrupt pending".
  localparam logic [31:0] INT_NONE = 32'd0;

  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_GAP_CYCLES = 4;
  localparam int DEFAULT_WIDTH      = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/int_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : int_fifo
//  Purpose  : Synchronous FIFO for queued interrupt words. The head entry is
//             shown combinationally from storage[rd_ptr].
//  Ports    : clock   - system clock
//             reset   - asynchronous, active-low
//             wr_en   - write request (ignored while full)
//             wr_data - word to store
//             rd_en   - pop request (ignored while empty)
//             head    - word at the read pointer
//             full    - occupancy equals DEPTH
//             empty   - occupancy equals zero
//             count   - occupancy, 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module int_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_wr;
  logic               w_rd;

  assign full  = (r_count == c_cnt_w'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // Full/empty are the pre-edge flags, so a pop while full never makes room
  // for a push in the same cycle.
  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/interrupt_injector.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_injector
//  Purpose  : Queues instruction words from an I/O bridge and presents them
//             one at a time on interrupt_instruction. After each processor
//             acknowledge the output is forced to zero for GAP_CYCLES cycles.
//  Ports    : clock                 - system clock
//             reset                 - asynchronous, active-low
//             push_valid/push_data  - word offered by the source
//             push_ready            - FIFO not full
//             interrupt_instruction - head word while presenting, else 0
//             int_ack               - processor consumed presented word
//             count                 - FIFO occupancy
//             drop_zero             - pulse: accepted push carried zero
//             overflow              - sticky: push offered while full
//  Revision : 1.0  initial release
// ============================================================================
module interrupt_injector
  import io_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int WIDTH      = DEFAULT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_valid,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   push_ready,
  output logic [WIDTH-1:0]       interrupt_instruction,
  input  logic                   int_ack,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop_zero,
  output logic                   overflow
);

  // Gap counter holds GAP_CYCLES-1 down to 0.
  localparam int                 c_gap_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(GAP_CYCLES - 1);
  localparam logic [WIDTH-1:0]   c_none     = WIDTH'(INT_NONE);

  state_t             r_state;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic               r_drop_zero;
  logic               r_overflow;

  logic               w_full;
  logic               w_empty;
  logic [WIDTH-1:0]   w_head;
  logic               w_accept;
  logic               w_is_zero;
  logic               w_wr_en;
  logic               w_pop;

  assign w_accept  = push_valid && !w_full;
  assign w_is_zero = (push_data == c_none);
  // Zero words are accepted (handshake completes) but never stored.
  assign w_wr_en   = w_accept && !w_is_zero;
  // Acks outside PRESENT are ignored.
  assign w_pop     = (r_state == PRESENT) && int_ack;

  int_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (w_wr_en),
    .wr_data (push_data),
    .rd_en   (w_pop),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          if (int_ack) begin
            r_state   <= GAP;
            r_gap_cnt <= c_gap_load;
          end
        end
        GAP: begin
          // Occupancy here already reflects the pop taken on entry.
          if (r_gap_cnt == '0) begin
            r_state <= w_empty ? IDLE : PRESENT;
          end else begin
            r_gap_cnt <= r_gap_cnt - c_gap_w'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_drop_zero <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_drop_zero <= w_accept && w_is_zero;
      r_overflow  <= r_overflow || (push_valid && w_full);
    end
  end

  // Moore output: the head only moves on a pop, so it is stable in PRESENT.
  assign interrupt_instruction = (r_state == PRESENT) ? w_head : c_none;
  assign push_ready            = !w_full;
  assign drop_zero             = r_drop_zero;
  assign overflow              = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_injector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interrupt_injector
//  Purpose  : Scoreboard bench for interrupt_injector. The driver advances a
//             queue-based reference model each clock edge and posts the
//             expected outputs; a monitor compares them on the falling edge
//             and checks every acknowledged word against the order of
//             accepted pushes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_interrupt_injector;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int WIDTH = 32;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   push_valid = 1'b0;
  logic [WIDTH-1:0]       push_data = '0;
  logic                   int_ack = 1'b0;
  logic                   push_ready;
  logic [WIDTH-1:0]       interrupt_instruction;
  logic [$clog2(DEPTH):0] count;
  logic                   drop_zero;
  logic                   overflow;

  interrupt_injector #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP),
    .WIDTH      (WIDTH)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .push_valid            (push_valid),
    .push_data             (push_data),
    .push_ready            (push_ready),
    .interrupt_instruction (interrupt_instruction),
    .int_ack               (int_ack),
    .count                 (count),
    .drop_zero             (drop_zero),
    .overflow              (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] out;
    int               cnt;
    bit               ready;
    bit               drop;
    bit               ovf;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] word_q[$];
  int               checks = 0;
  int               errors = 0;

  // Reference model: a queue of stored words, whether the head is being
  // shown, and the earliest edge at which a new word may be shown.
  logic [WIDTH-1:0] m_fifo[$];
  bit               m_presenting = 1'b0;
  bit               m_ovf = 1'b0;
  bit               m_drop = 1'b0;
  int               m_edge = 0;
  int               m_eligible = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, post the
  // expected post-edge outputs, and return 1ns after the edge.
  task automatic step(input bit pv, input logic [WIDTH-1:0] pd, input bit ack);
    bit   full;
    bit   acc;
    bit   pop;
    bit   had;
    exp_t e;
    push_valid = pv;
    push_data  = pd;
    int_ack    = ack;
    @(posedge clock);
    m_edge++;
    full   = (m_fifo.size() == DEPTH);
    acc    = pv && !full;
    pop    = m_presenting && ack;
    had    = (m_fifo.size() > 0);
    m_ovf  = m_ovf || (pv && full);
    m_drop = acc && (pd == '0);
    if (pop) begin
      void'(m_fifo.pop_front());
      m_presenting = 1'b0;
      m_eligible   = m_edge + GAP;
    end else if (!m_presenting && had && m_edge >= m_eligible) begin
      m_presenting = 1'b1;
    end
    if (acc && pd != '0) begin
      m_fifo.push_back(pd);
      word_q.push_back(pd);
    end
    e.out   = m_presenting ? m_fifo[0] : '0;
    e.cnt   = m_fifo.size();
    e.ready = (m_fifo.size() < DEPTH);
    e.drop  = m_drop;
    e.ovf   = m_ovf;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out"},   interrupt_instruction, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_ready"}, 32'(push_ready), 32'd1);
    chk({tag, "_drop"},  32'(drop_zero), 32'd0);
    chk({tag, "_ovf"},   32'(overflow), 32'd0);
  endtask

  // Asynchronous reset between the falling and rising edges.
  task automatic mid_cycle_reset();
    @(negedge clock);
    #2;
    reset      = 1'b0;
    push_valid = 1'b0;
    int_ack    = 1'b0;
    m_fifo.delete();
    word_q.delete();
    m_presenting = 1'b0;
    m_ovf        = 1'b0;
    m_drop       = 1'b0;
    m_eligible   = 0;
    #1;
    check_reset_values("async_rst");
    #1;
    reset = 1'b1;
  endtask

  // Monitor: per-cycle expectations, plus word order on each acknowledge.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out",   interrupt_instruction, e.out);
      chk("count", 32'(count), 32'(e.cnt));
      chk("ready", 32'(push_ready), 32'(e.ready));
      chk("drop",  32'(drop_zero), 32'(e.drop));
      chk("ovf",   32'(overflow), 32'(e.ovf));
    end
    if (reset && int_ack && interrupt_instruction != '0) begin
      if (word_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_word: got %h expected none (scoreboard empty)", interrupt_instruction);
      end else begin
        chk("ack_word", interrupt_instruction, word_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    #2 reset = 1'b0;
    #1 check_reset_values("por");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Single word: two-cycle latency, then held while unacknowledged.
    step(1'b1, 32'h0000_1234, 1'b0);
    chk("lat_edgeN", interrupt_instruction, 32'd0);
    step(1'b0, '0, 1'b0);
    chk("lat_edgeN1", interrupt_instruction, 32'h0000_1234);
    repeat (10) step(1'b0, '0, 1'b0);
    chk("hold_out", interrupt_instruction, 32'h0000_1234);
    chk("hold_count", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1);

    // Back-to-back words with acks and the drain gap.
    step(1'b1, 32'hA, 1'b0);
    step(1'b1, 32'hB, 1'b0);
    repeat (6) step(1'b0, '0, 1'b0);
    repeat (15) step(1'b0, '0, 1'b1);
    chk("ab_idle_out", interrupt_instruction, 32'd0);
    chk("ab_idle_count", 32'(count), 32'd0);

    // Overfill: nine pushes into eight entries.
    for (int i = 1; i <= 9; i++) step(1'b1, 32'(i), 1'b0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(push_ready), 32'd0);
    chk("full_ovf", 32'(overflow), 32'd1);
    repeat (2) step(1'b0, '0, 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Push and pop while full: push rejected, then accepted next cycle.
    step(1'b1, 32'h99, 1'b1);
    chk("fullpop_count", 32'(count), 32'd7);
    step(1'b1, 32'h99, 1'b0);
    chk("refill_count", 32'(count), 32'd8);
    repeat (9 * (GAP + 1) + 5) step(1'b0, '0, 1'b1);
    chk("drain_count", 32'(count), 32'd0);

    // Zero word is discarded with a one-cycle pulse.
    step(1'b1, 32'd0, 1'b0);
    chk("zero_drop", 32'(drop_zero), 32'd1);
    chk("zero_count", 32'(count), 32'd0);
    step(1'b0, '0, 1'b0);
    chk("zero_drop_end", 32'(drop_zero), 32'd0);

    // Reset while the second of three words is presented.
    step(1'b1, 32'h111, 1'b0);
    step(1'b1, 32'h222, 1'b0);
    step(1'b1, 32'h333, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    repeat (GAP) step(1'b0, '0, 1'b0);
    chk("second_word", interrupt_instruction, 32'h222);
    mid_cycle_reset();
    step(1'b1, 32'h444, 1'b0);
    chk("post_rst_lat0", interrupt_instruction, 32'd0);
    step(1'b0, '0, 1'b0);
    chk("post_rst_lat1", interrupt_instruction, 32'h444);
    repeat (GAP + 2) step(1'b0, '0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] d;
      d = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      step(1'($urandom_range(0, 1)), d, ($urandom_range(0, 9) < 4));
    end
    repeat (DEPTH * (GAP + 1) + 10) step(1'b0, '0, 1'b1);
    chk("final_count", 32'(count), 32'd0);
    chk("words_left", 32'(word_q.size()), 32'd0);

    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
